uart_frame_rx: RTL and testbench

UART_FRAME_RX -- requirements
Module: uart_frame_rx

---
 rtl/uart_pkg.sv | 35 +++
 rtl/uart_frame_buf.sv | 32 +++
 rtl/uart_frame_rx.sv | 183 ++++++++++++++++++
 tb/tb_uart_frame_rx.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART frame receiver: FSM states, error codes,
// the default start-of-frame marker and small elaboration/encoding helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHK,
    ST_DRAIN
  } frame_state_e;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_CHK  = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

  // Address width for a buffer of the given depth; a depth of one still needs one bit.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // The three error causes are mutually exclusive by construction; the order only
  // makes the encoding total.
  function automatic logic [1:0] err_code_of(input logic len_bad, input logic chk_bad,
                                             input logic tmo_hit);
    if (len_bad) return ERR_LEN;
    if (chk_bad) return ERR_CHK;
    if (tmo_hit) return ERR_TMO;
    return ERR_NONE;
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer for uart_frame_rx: DEPTH x DATA_W registers, one write port and
// one registered read port (read data appears the cycle after the address).
module uart_frame_buf #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_p1;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read stage: the read register is cleared so the output beat reads zero after reset.
  always_ff @(posedge clk) begin
    if (!rstn) rd_data_p1 <= '0;
    else       rd_data_p1 <= mem[raddr];
  end

  assign rdata = rd_data_p1;

endmodule

// File: rtl/uart_frame_rx.sv
// Byte-stream frame receiver: SOF, LEN, LEN payload bytes, CHK (XOR of LEN and payload).
// Good frames are replayed from a buffer as a ready/valid stream. Optional inter-byte
// timeout is enabled by defining UART_FRAME_TIMEOUT_EN.
module uart_frame_rx
  import uart_pkg::*;
#(
  parameter int         MAX_LEN        = 16,
  parameter logic [7:0] SOF_BYTE       = SOF_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       overrun
);

  localparam int            IW        = $clog2(MAX_LEN + 1);
  localparam int            AW        = addr_width(MAX_LEN);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [IW-1:0] IDX_ONE   = IW'(1);
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);

  if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("uart_frame_rx: parameter out of range");
  end

  frame_state_e  state_q, state_d;
  logic [IW-1:0] len_q, len_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    xor_q, xor_d;
  logic          ok_d, err_d, ovr_d;
  logic [1:0]    code_d;
  logic          len_bad, chk_bad, tmo_hit;
  logic          buf_we;
  logic [AW-1:0] buf_raddr;
  logic          last_idx;

  // idx_q is the write index while collecting and the beat index while draining.
  assign last_idx  = (idx_q == len_q - IDX_ONE);
  assign out_valid = (state_q == ST_DRAIN);
  assign out_last  = out_valid && last_idx;

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_q, tmo_d;

  always_comb begin
    tmo_d   = '0;
    tmo_hit = 1'b0;
    if ((state_q inside {ST_LEN, ST_PAYLOAD, ST_CHK}) && !in_valid) begin
      if (tmo_q == TMO_LAST) tmo_hit = 1'b1;
      else                   tmo_d   = tmo_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    xor_d     = xor_q;
    ok_d      = 1'b0;
    ovr_d     = 1'b0;
    len_bad   = 1'b0;
    chk_bad   = 1'b0;
    buf_we    = 1'b0;
    buf_raddr = idx_q[AW-1:0];

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid && in_data == SOF_BYTE) state_d = ST_LEN;
      end
      ST_LEN: begin
        if (in_valid) begin
          if (in_data == 8'd0 || in_data > MAX_LEN_B) begin
            len_bad = 1'b1;
            state_d = ST_IDLE;
          end else begin
            len_d   = in_data[IW-1:0];
            idx_d   = '0;
            xor_d   = in_data;
            state_d = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (in_valid) begin
          buf_we = 1'b1;
          xor_d  = xor_q ^ in_data;
          idx_d  = idx_q + IDX_ONE;
          if (last_idx) state_d = ST_CHK;
        end
      end
      ST_CHK: begin
        // Prefetch beat 0 so it is on out_data the cycle DRAIN begins.
        buf_raddr = '0;
        if (in_valid) begin
          if (in_data == xor_q) begin
            ok_d    = 1'b1;
            idx_d   = '0;
            state_d = ST_DRAIN;
          end else begin
            chk_bad = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_DRAIN: begin
        ovr_d = in_valid;
        if (out_ready) begin
          if (last_idx) begin
            idx_d   = '0;
            state_d = ST_IDLE;
          end else begin
            idx_d     = idx_q + IDX_ONE;
            buf_raddr = idx_q[AW-1:0] + ADDR_ONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (tmo_hit) state_d = ST_IDLE;
    err_d  = len_bad | chk_bad | tmo_hit;
    code_d = err_code_of(len_bad, chk_bad, tmo_hit);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= ERR_NONE;
      overrun   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      frame_ok  <= ok_d;
      frame_err <= err_d;
      err_code  <= code_d;
      overrun   <= ovr_d;
    end
  end

  // Length and running checksum are only meaningful once a frame has started.
  always_ff @(posedge clk) begin
    len_q <= len_d;
    xor_q <= xor_d;
  end

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .ADDR_W(AW),
    .DATA_W(8)
  ) u_buf (
    .clk  (clk),
    .rstn (rstn),
    .we   (buf_we),
    .waddr(idx_q[AW-1:0]),
    .wdata(in_data),
    .raddr(buf_raddr),
    .rdata(out_data)
  );

endmodule

// File: tb/tb_uart_frame_rx.sv
// Self-checking bench for uart_frame_rx: table of frames plus hand sequences for
// stalls, overrun, max length, timeout and mid-frame reset.
module tb_uart_frame_rx;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] in_data;
  logic       in_valid;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       overrun;

  uart_frame_rx #(
    .MAX_LEN       (16),
    .SOF_BYTE      (8'hA5),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .in_data  (in_data),
    .in_valid (in_valid),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .frame_ok (frame_ok),
    .frame_err(frame_err),
    .err_code (err_code),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       last;
  } beat_t;

  beat_t sb[$];

  typedef struct {
    logic [63:0] bytes;
    int          n;
    int          ok;
    int          err;
    logic [1:0]  code;
    int          nb;
    logic [31:0] beats;
  } vec_t;

  vec_t vt[9];

  int         mon_ok  = 0;
  int         mon_err = 0;
  int         mon_ovr = 0;
  logic [1:0] mon_code = 2'b00;
  logic       stall_q = 1'b0;
  logic [7:0] hold_data = 8'h00;
  logic       hold_last = 1'b0;
  beat_t      mon_e;

  always @(negedge clk) begin
    if (!rstn) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check("hold_valid", 32'(out_valid), 1);
        check("hold_data", 32'(out_data), 32'(hold_data));
        check("hold_last", 32'(out_last), 32'(hold_last));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("beat_unexpected", 32'(out_data), -1);
        end else begin
          mon_e = sb.pop_front();
          check("beat_data", 32'(out_data), 32'(mon_e.data));
          check("beat_last", 32'(out_last), 32'(mon_e.last));
        end
      end
      stall_q   = out_valid && !out_ready;
      hold_data = out_data;
      hold_last = out_last;
      if (frame_ok || frame_err || overrun)
        check("pulse_excl", int'(frame_ok) + int'(frame_err) + int'(overrun), 1);
      if (frame_ok) mon_ok++;
      if (frame_err) begin
        mon_err++;
        mon_code = err_code;
      end
      if (overrun) mon_ovr++;
    end
  end

  task automatic push_beat(input logic [7:0] d, input logic l);
    beat_t e;
    e.data = d;
    e.last = l;
    sb.push_back(e);
  endtask

  task automatic cyc(input logic v, input logic [7:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 8'h00);
  endtask

  task automatic wait_drain(input int max);
    int k = 0;
    while ((sb.size() != 0 || out_valid) && k < max) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("drain_left", sb.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int          ok0, err0, ovr0, hit;
    logic [63:0] sh;
    logic [31:0] bsh;
    logic [7:0]  b, chk;

    rstn      = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;

    vt[0] = '{64'hA5_03_11_22_33_03_00_00, 6, 1, 0, 2'b00, 3, 32'h11_22_33_00};
    vt[1] = '{64'hA5_03_11_22_33_00_00_00, 6, 0, 1, 2'b10, 0, 32'h0};
    vt[2] = '{64'hA5_02_10_20_FF_00_00_00, 5, 0, 1, 2'b10, 0, 32'h0};
    vt[3] = '{64'hA5_01_7E_7F_00_00_00_00, 4, 1, 0, 2'b00, 1, 32'h7E_00_00_00};
    vt[4] = '{64'hA5_00_00_00_00_00_00_00, 2, 0, 1, 2'b01, 0, 32'h0};
    vt[5] = '{64'hA5_11_00_00_00_00_00_00, 2, 0, 1, 2'b01, 0, 32'h0};
    vt[6] = '{64'h00_55_A5_01_7E_7F_00_00, 6, 1, 0, 2'b00, 1, 32'h7E_00_00_00};
    vt[7] = '{64'hA5_02_C3_3C_FD_00_00_00, 5, 1, 0, 2'b00, 2, 32'hC3_3C_00_00};
    vt[8] = '{64'h12_A5_04_01_02_04_08_0B, 8, 1, 0, 2'b00, 4, 32'h01_02_04_08};

    repeat (3) @(posedge clk);
    #1;
    check("rst_ctl", 32'({out_valid, out_last, frame_ok, frame_err, overrun}), 0);
    check("rst_data", 32'({err_code, out_data}), 0);
    rstn = 1'b1;
    idle(2);

    for (int i = 0; i < 9; i++) begin
      ok0  = mon_ok;
      err0 = mon_err;
      ovr0 = mon_ovr;
      bsh  = vt[i].beats;
      for (int j = 0; j < vt[i].nb; j++) begin
        push_beat(bsh[31:24], j == vt[i].nb - 1);
        bsh = bsh << 8;
      end
      sh = vt[i].bytes;
      for (int j = 0; j < vt[i].n; j++) begin
        cyc(1'b1, sh[63:56]);
        sh = sh << 8;
      end
      idle(3);
      wait_drain(40);
      idle(2);
      check($sformatf("v%0d_ok", i), mon_ok - ok0, vt[i].ok);
      check($sformatf("v%0d_err", i), mon_err - err0, vt[i].err);
      check($sformatf("v%0d_ovr", i), mon_ovr - ovr0, 0);
      if (vt[i].err != 0) check($sformatf("v%0d_code", i), 32'(mon_code), 32'(vt[i].code));
    end

    // Stall pattern 1,0,0,1 with a byte injected while stalled.
    ok0 = mon_ok; err0 = mon_err; ovr0 = mon_ovr;
    push_beat(8'h11, 1'b0);
    push_beat(8'h22, 1'b0);
    push_beat(8'h33, 1'b1);
    cyc(1'b1, 8'hA5); cyc(1'b1, 8'h03); cyc(1'b1, 8'h11);
    cyc(1'b1, 8'h22); cyc(1'b1, 8'h33); cyc(1'b1, 8'h03);
    out_ready = 1'b1; cyc(1'b0, 8'h00);
    out_ready = 1'b0; cyc(1'b1, 8'h5A);
    out_ready = 1'b0; cyc(1'b0, 8'h00);
    out_ready = 1'b1;
    wait_drain(20);
    idle(2);
    check("stall_ok", mon_ok - ok0, 1);
    check("stall_ovr", mon_ovr - ovr0, 1);
    check("stall_err", mon_err - err0, 0);

    // Byte arriving on the cycle of the last beat is dropped too.
    ok0 = mon_ok; ovr0 = mon_ovr; err0 = mon_err;
    push_beat(8'h7E, 1'b1);
    cyc(1'b1, 8'hA5); cyc(1'b1, 8'h01); cyc(1'b1, 8'h7E); cyc(1'b1, 8'h7F);
    cyc(1'b1, 8'h5A);
    idle(3);
    wait_drain(20);
    check("lastovr_ovr", mon_ovr - ovr0, 1);
    check("lastovr_ok", mon_ok - ok0, 1);
    check("lastovr_err", mon_err - err0, 0);

    // Maximum legal length.
    ok0 = mon_ok; err0 = mon_err;
    chk = 8'd16;
    cyc(1'b1, 8'hA5);
    cyc(1'b1, 8'd16);
    for (int j = 0; j < 16; j++) begin
      b = 8'(j * 7 + 1);
      push_beat(b, j == 15);
      chk = chk ^ b;
      cyc(1'b1, b);
    end
    cyc(1'b1, chk);
    wait_drain(60);
    idle(2);
    check("max_ok", mon_ok - ok0, 1);
    check("max_err", mon_err - err0, 0);

    // Stalled frame: timeout or indefinite wait depending on build.
    ok0 = mon_ok; err0 = mon_err;
    cyc(1'b1, 8'hA5); cyc(1'b1, 8'h04); cyc(1'b1, 8'h11);
    hit = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (frame_err && hit == 0) hit = k;
    end
`ifdef UART_FRAME_TIMEOUT_EN
    check("tmo_cycle", hit, 50);
    check("tmo_code", 32'(mon_code), 3);
    check("tmo_err", mon_err - err0, 1);
`else
    check("no_tmo", hit, 0);
    push_beat(8'h11, 1'b0);
    push_beat(8'h22, 1'b0);
    push_beat(8'h33, 1'b0);
    push_beat(8'h44, 1'b1);
    cyc(1'b1, 8'h22); cyc(1'b1, 8'h33); cyc(1'b1, 8'h44); cyc(1'b1, 8'h40);
    wait_drain(20);
    idle(2);
    check("late_ok", mon_ok - ok0, 1);
    check("late_err", mon_err - err0, 0);
`endif

    // Reset in the middle of PAYLOAD discards the frame.
    cyc(1'b1, 8'hA5); cyc(1'b1, 8'h03); cyc(1'b1, 8'h11);
    rstn = 1'b0;
    cyc(1'b0, 8'h00);
    check("mid_rst_ctl", 32'({out_valid, out_last, frame_ok, frame_err, overrun}), 0);
    check("mid_rst_data", 32'({err_code, out_data}), 0);
    rstn = 1'b1;
    ok0 = mon_ok; err0 = mon_err;
    push_beat(8'h44, 1'b1);
    cyc(1'b1, 8'hA5); cyc(1'b1, 8'h01); cyc(1'b1, 8'h44); cyc(1'b1, 8'h45);
    idle(2);
    wait_drain(20);
    idle(2);
    check("post_rst_ok", mon_ok - ok0, 1);
    check("post_rst_err", mon_err - err0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
